parity_frame_tx: RTL and testbench
==================================

Name: parity_frame_tx

Overview:
Sequences a parity generator into a serial frame transmitter. Accepts one DATA_W-bit word per valid/ready handshake and computes its parity bit (even or odd). Shifts out start bit, data LSB-first, parity bit and stop bit, each held for CLKS_PER_BIT clocks. Sits between a word-level producer and a single-wire serial link.

Parameters:
DATA_W, 8, width of the data word (legal range 2..32)
CLKS_PER_BIT, 4, clocks each serial bit is held (legal range >=1)
ODD_PARITY, 0, 0 = even parity (total 1s across data+parity is even), 1 = odd parity

Ports:
clk  input  1  system clock; all logic is rising-edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  producer has a word on in_data
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  word to transmit
tx  output  1  serial line, idle-high
busy  output  1  frame in progress
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-low (rst_n). Sampled only on clk rising edge.
- Reset values: tx=1, busy=0, done=0, in_ready=1, state=IDLE, bit counter=0, clock-divider counter=0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- in_ready = (state==IDLE). It is decoded from registered state, with no combinational path from in_valid.
- Handshake: transfer occurs when in_valid && in_ready at a rising edge.
  - At that edge: latch in_data into the shift register.
  - Latch par = (XOR-reduce of in_data) ^ ODD_PARITY.
  - Move to START and drive tx<=0, busy<=1.
- in_data/in_valid are ignored while not IDLE. No word is lost or queued.
- Each state holds tx for exactly CLKS_PER_BIT cycles, counted by the divider counter, which wraps to 0 on each bit boundary.
- START: tx=0. Then DATA.
- DATA: tx = shift register bit 0, shifting right each bit boundary. The bit counter counts 0..DATA_W-1. After bit DATA_W-1 go to PARITY.
- PARITY: tx = latched par. Then STOP.
- STOP: tx=1. At its final cycle boundary: go to IDLE, busy<=0, done<=1 for exactly one cycle.
- Latency: with the handshake at edge N, tx is low during cycles N+1..N+CLKS_PER_BIT.
  - The frame occupies (DATA_W+3)*CLKS_PER_BIT cycles.
  - done is high in the first IDLE cycle after the frame.
- Back-to-back: in the cycle done=1, in_ready=1. A word handshaken then starts the next frame with no idle bit-time. tx stays 1 for that one cycle only.
- tx, busy and done are registered outputs (glitch-free).
- Reset mid-frame (rst_n=0 at any edge):
  - Next cycle: tx=1, IDLE, busy=0.
  - No done pulse; the partial frame is abandoned.
  - A handshake in the same cycle as reset is ignored.
- CLKS_PER_BIT=1: each state lasts one cycle. The divider counter is constant 0.

Decomposition:
- Shared package parity_pkg holds:
  - the state enum (IDLE/START/DATA/PARITY/STOP) as 3-bit localparams;
  - PAR_EVEN=0 and PAR_ODD=1 constants;
  - a CLOG2 helper for counter widths.
- One sub-module is natural: parity_calc (combinational XOR-reduce of a DATA_W vector plus odd select). It is instantiated once, feeding the par latch.

Test Plan:
1. Reset with rst_n=0 for 2 cycles -> tx=1, busy=0, done=0, in_ready=1 after first edge.
2. DATA_W=8, CLKS_PER_BIT=4, even parity, send 0xA5 -> tx sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,0(parity),1(stop). busy high 44 cycles; done pulses on cycle 45 only.
3. Even parity with 0x01 -> parity bit 1. ODD_PARITY=1 with 0x01 -> parity bit 0. ODD_PARITY=1 with 0x00 -> parity bit 1.
4. Hold in_valid=1 with data 0x3C then 0xFF.
   - First frame: parity bit 0.
   - The second word is accepted in the done cycle, so its start bit begins the very next cycle.
   - Second frame: parity bit 0; no in_valid sampled during the first frame.
5. Pulse rst_n=0 mid-DATA (bit 3) -> next cycle tx=1, busy=0, IDLE, no done. A fresh 0x5A is then sent correctly with parity 0.
6. CLKS_PER_BIT=1, send 0x80 -> 11-cycle frame tx=0,0,0,0,0,0,0,0,1,1,1; done on cycle 12.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame transmitter.
//   state_t / IDLE..STOP : 3-bit FSM state codes
//   PAR_EVEN / PAR_ODD   : parity-select constants
//   clog2()              : ceil(log2(v)), sizes the bit and divider counters
package parity_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t START  = 3'd1;
  localparam state_t DATA   = 3'd2;
  localparam state_t PARITY = 3'd3;
  localparam state_t STOP   = 3'd4;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity of a DATA_W-bit word.
//   data : word to protect
//   par  : XOR of all data bits, inverted when ODD_PARITY selects odd parity
module parity_calc
  import parity_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = PAR_EVEN
) (
  input  logic [DATA_W-1:0] data,
  output logic              par
);

  localparam logic ODD_SEL = (ODD_PARITY != PAR_EVEN);

  assign par = (^data) ^ ODD_SEL;

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start bit, DATA_W data bits LSB-first, parity
// bit, stop bit; every bit held for CLKS_PER_BIT clocks.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_valid/in_ready  : word handshake (in_ready is high only while idle)
//   in_data            : word to send
//   tx                 : serial line, idle high
//   busy               : frame in progress
//   done               : one-cycle pulse in the first idle cycle after a frame
module parity_frame_tx
  import parity_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int ODD_PARITY   = PAR_EVEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = clog2(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  state_t              state, state_d;
  logic [DIV_W-1:0]    div_cnt, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic                par_q, par_d, par_w;
  logic                tx_d, busy_d, done_d;
  logic                accept, bit_end;

  parity_calc #(.DATA_W(DATA_W), .ODD_PARITY(ODD_PARITY)) u_par (
    .data (in_data),
    .par  (par_w)
  );

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  // With CLKS_PER_BIT=1 DIV_LAST is 0 and the divider never leaves 0,
  // so every cycle is a bit boundary.
  assign bit_end  = (div_cnt == DIV_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept)                          state_d = START;
      START:   if (bit_end)                         state_d = DATA;
      DATA:    if (bit_end && bit_cnt == BIT_LAST)  state_d = PARITY;
      PARITY:  if (bit_end)                         state_d = STOP;
      STOP:    if (bit_end)                         state_d = IDLE;
      default:                                      state_d = IDLE;
    endcase
  end

  // Datapath next values: divider, bit counter, shift register, parity latch
  always_comb begin
    div_cnt_d = div_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    par_d     = par_q;
    if (state == IDLE) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
      if (accept) begin
        shreg_d = in_data;
        par_d   = par_w;
      end
    end else begin
      div_cnt_d = bit_end ? '0 : div_cnt + 1'b1;
      if (state == DATA && bit_end) begin
        // Shift at every data boundary so shreg[0] is always the next bit out
        shreg_d   = shreg >> 1;
        bit_cnt_d = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // Output logic: decoded from next state so tx/busy/done can be registered
  // and still change on the same edge as the state.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state == STOP) && (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      div_cnt <= div_cnt_d;
      bit_cnt <= bit_cnt_d;
      shreg   <= shreg_d;
      par_q   <= par_d;
      tx      <= tx_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three instances (even/4, odd/4, even/1) checked
// every cycle against a frame-queue model, plus hand-computed tx sequences.
module tb_parity_frame_tx;

  localparam int NI = 3;
  localparam int CPB [NI] = '{4, 4, 1};
  localparam int ODD [NI] = '{0, 1, 0};

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NI-1:0]   in_valid;
  logic [7:0]      in_data [NI];
  logic [NI-1:0]   in_ready, tx, busy, done;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .ODD_PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
  parity_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .ODD_PARITY(0)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each accepted word becomes a queue of per-cycle tx values.
  bit   exp_q [NI][$];
  bit   exp_done [NI];
  bit   armed = 1'b0;

  logic cap_tx   [0:127];
  logic cap_busy [0:127];
  logic cap_done [0:127];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      if (armed) begin
        chk($sformatf("tx%0d", k),   8'(tx[k]),       8'(exp_q[k].size() > 0 ? exp_q[k][0] : 1'b1));
        chk($sformatf("busy%0d", k), 8'(busy[k]),     8'(exp_q[k].size() > 0));
        chk($sformatf("rdy%0d", k),  8'(in_ready[k]), 8'(exp_q[k].size() == 0));
        chk($sformatf("done%0d", k), 8'(done[k]),     8'(exp_done[k]));
      end
      // What the next cycle must look like
      if (!rst_n) begin
        exp_q[k].delete();
        exp_done[k] = 1'b0;
      end else if (exp_q[k].size() > 0) begin
        void'(exp_q[k].pop_front());
        exp_done[k] = (exp_q[k].size() == 0);
      end else begin
        exp_done[k] = 1'b0;
        if (in_valid[k]) begin
          bit p;
          p = ODD[k][0];
          for (int b = 0; b < 8; b++) p = p ^ in_data[k][b];
          for (int c = 0; c < CPB[k]; c++) exp_q[k].push_back(1'b0);
          for (int b = 0; b < 8; b++)
            for (int c = 0; c < CPB[k]; c++) exp_q[k].push_back(in_data[k][b]);
          for (int c = 0; c < CPB[k]; c++) exp_q[k].push_back(p);
          for (int c = 0; c < CPB[k]; c++) exp_q[k].push_back(1'b1);
        end
      end
    end
    if (!rst_n) armed = 1'b1;
  endtask

  // One clock: model check on the falling edge, then return just after the
  // rising edge so new inputs are set up for the next edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] d);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    tick();
  endtask

  // Record cycles 1..n after the handshake edge. Hooks at cycle i change
  // inputs that the DUT samples at the end of cycle i.
  task automatic capture(input int k, input int n, input int drop_at,
                         input int chg_at, input logic [7:0] nd, input int rst_at);
    for (int i = 1; i <= n; i++) begin
      if (i == drop_at)    in_valid[k] = 1'b0;
      if (i == chg_at)     in_data[k]  = nd;
      if (i == rst_at)     rst_n = 1'b0;
      if (i == rst_at + 1) rst_n = 1'b1;
      cap_tx[i]   = tx[k];
      cap_busy[i] = busy[k];
      cap_done[i] = done[k];
      tick();
    end
  endtask

  function automatic int mid(input int k, input int b);
    return 1 + b * CPB[k] + CPB[k] / 2;
  endfunction

  function automatic int count(input int which, input int lo, input int hi);
    int s;
    s = 0;
    for (int i = lo; i <= hi; i++)
      s += (which == 0) ? int'(cap_busy[i]) : int'(cap_done[i]);
    return s;
  endfunction

  int lit_a5 [11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
  int lit_80 [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    rst_n    = 1'b0;
    in_valid = '0;
    for (int k = 0; k < NI; k++) in_data[k] = '0;

    // Reset held for two edges
    tick();
    chk("rst_tx",   8'(tx),       8'b111);
    chk("rst_busy", 8'(busy),     8'b000);
    chk("rst_done", 8'(done),     8'b000);
    chk("rst_rdy",  8'(in_ready), 8'b111);
    tick();
    rst_n = 1'b1;
    tick();

    // 0xA5, even parity, 4 clocks per bit
    send(0, 8'hA5);
    capture(0, 50, 1, -1, 8'h00, -1);
    for (int b = 0; b < 11; b++)
      chk($sformatf("a5_bit%0d", b), 8'(cap_tx[mid(0, b)]), 8'(lit_a5[b]));
    chk("a5_busy_cycles", 8'(count(0, 1, 50)), 8'd44);
    chk("a5_done_at45",   8'(cap_done[45]),    8'd1);
    chk("a5_done_count",  8'(count(1, 1, 50)), 8'd1);

    // Parity polarity
    send(0, 8'h01);
    capture(0, 46, 1, -1, 8'h00, -1);
    chk("even_01_par", 8'(cap_tx[mid(0, 9)]), 8'd1);
    send(1, 8'h01);
    capture(1, 46, 1, -1, 8'h00, -1);
    chk("odd_01_par", 8'(cap_tx[mid(1, 9)]), 8'd0);
    send(1, 8'h00);
    capture(1, 46, 1, -1, 8'h00, -1);
    chk("odd_00_par", 8'(cap_tx[mid(1, 9)]), 8'd1);

    // Back-to-back: valid held, data switches to 0xFF mid-frame
    send(0, 8'h3C);
    capture(0, 100, 46, 1, 8'hFF, -1);
    chk("b2b_par1",     8'(cap_tx[mid(0, 9)]),       8'd0);
    chk("b2b_done45",   8'(cap_done[45]),            8'd1);
    chk("b2b_tx45",     8'(cap_tx[45]),              8'd1);
    chk("b2b_start46",  8'(cap_tx[46]),              8'd0);
    chk("b2b_busy46",   8'(cap_busy[46]),            8'd1);
    chk("b2b_d0_2nd",   8'(cap_tx[45 + mid(0, 1)]),  8'd1);
    chk("b2b_par2",     8'(cap_tx[45 + mid(0, 9)]),  8'd0);
    chk("b2b_done90",   8'(cap_done[90]),            8'd1);

    // Reset during data bit 3, then a clean 0x5A frame
    send(0, 8'h33);
    capture(0, 60, 1, -1, 8'h00, 18);
    chk("mr_tx18",    8'(cap_tx[18]),       8'd0);
    chk("mr_busy18",  8'(cap_busy[18]),     8'd1);
    chk("mr_tx19",    8'(cap_tx[19]),       8'd1);
    chk("mr_busy19",  8'(cap_busy[19]),     8'd0);
    chk("mr_no_done", 8'(count(1, 19, 60)), 8'd0);
    send(0, 8'h5A);
    capture(0, 50, 1, -1, 8'h00, -1);
    chk("5a_par",  8'(cap_tx[mid(0, 9)]), 8'd0);
    chk("5a_done", 8'(cap_done[45]),      8'd1);

    // Handshake in a reset cycle is ignored
    rst_n       = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h11;
    tick();
    rst_n       = 1'b0;
    in_valid[0] = 1'b0;
    rst_n       = 1'b1;
    chk("rst_hs_busy", 8'(busy[0]), 8'd0);
    tick();
    tick();

    // One clock per bit: 0x80
    send(2, 8'h80);
    capture(2, 15, 1, -1, 8'h00, -1);
    for (int b = 0; b < 11; b++)
      chk($sformatf("c1_bit%0d", b), 8'(cap_tx[mid(2, b)]), 8'(lit_80[b]));
    chk("c1_busy_cycles", 8'(count(0, 1, 15)), 8'd11);
    chk("c1_done12",      8'(cap_done[12]),    8'd1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
